// File: rtl/exu_disp_pkg.sv
// Shared decode-info field layout, dispatch unit indices and FSM encoding for exu_disp.
// Group field and AGU load flag sit at the bottom of the decode-info word.
package exu_disp_pkg;

  localparam int XLEN          = 32;
  localparam int PC_SIZE       = 32;
  localparam int RFIDX_WIDTH   = 5;
  localparam int NUM_REGS      = 1 << RFIDX_WIDTH;
  localparam int DECINFO_WIDTH = 16;

  localparam int DECINFO_GRP_LSB   = 0;
  localparam int DECINFO_GRP_WIDTH = 2;
  localparam int DECINFO_AGU_LOAD  = 2;

  localparam logic [1:0] DECINFO_GRP_ALU    = 2'd0;
  localparam logic [1:0] DECINFO_GRP_MULDIV = 2'd1;
  localparam logic [1:0] DECINFO_GRP_AGU    = 2'd2;
  localparam logic [1:0] DECINFO_GRP_BJP    = 2'd3;

  localparam int UNIT_ALU    = 0;
  localparam int UNIT_MULDIV = 1;
  localparam int UNIT_AGU    = 2;
  localparam int UNIT_BJP    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_TRAP = 2'd2
  } disp_state_e;

  function automatic logic [1:0] decinfo_grp(input logic [DECINFO_WIDTH-1:0] info);
    return info[DECINFO_GRP_LSB +: DECINFO_GRP_WIDTH];
  endfunction

  function automatic logic [3:0] grp_onehot(input logic [1:0] grp);
    logic [3:0] oh;
    oh = 4'b0000;
    case (grp)
      DECINFO_GRP_ALU:    oh[UNIT_ALU]    = 1'b1;
      DECINFO_GRP_MULDIV: oh[UNIT_MULDIV] = 1'b1;
      DECINFO_GRP_AGU:    oh[UNIT_AGU]    = 1'b1;
      default:            oh[UNIT_BJP]    = 1'b1;
    endcase
    return oh;
  endfunction

  // Only long-latency results (mul/div and loads) are tracked as pending.
  function automatic logic sets_pending(input logic [DECINFO_WIDTH-1:0] info);
    return (decinfo_grp(info) == DECINFO_GRP_MULDIV) ||
           ((decinfo_grp(info) == DECINFO_GRP_AGU) && info[DECINFO_AGU_LOAD]);
  endfunction

endpackage

// File: rtl/exu_disp_sboard.sv
// Pending-writeback scoreboard: set on long-latency dispatch, clear on writeback, hazard query.
// A same-cycle writeback is already visible to the query; a same-cycle set wins over clear.
module exu_disp_sboard
  import exu_disp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [RFIDX_WIDTH-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [RFIDX_WIDTH-1:0] clr_idx,
  input  logic                   rs1en,
  input  logic [RFIDX_WIDTH-1:0] rs1idx,
  input  logic                   rs2en,
  input  logic [RFIDX_WIDTH-1:0] rs2idx,
  input  logic                   rdwen,
  input  logic [RFIDX_WIDTH-1:0] rdidx,
  output logic                   hazard,
  output logic [NUM_REGS-1:0]    pending
);

  logic [NUM_REGS-1:0] one_hot_lsb;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] live;

  assign one_hot_lsb = NUM_REGS'(1);
  assign set_mask    = set_en ? (one_hot_lsb << set_idx) : '0;
  assign clr_mask    = clr_en ? (one_hot_lsb << clr_idx) : '0;
  assign live        = pending & ~clr_mask;

  assign hazard = (rs1en & live[rs1idx]) | (rs2en & live[rs2idx]) | (rdwen & live[rdidx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (live | set_mask) & ~one_hot_lsb;
    end
  end

endmodule

// File: rtl/exu_disp.sv
// Single-entry dispatch stage steering decoded instructions to BJP/AGU/MULDIV/ALU with RAW/WAW scoreboard.
// EXU_DISP_PASSTHRU_EN: idle, hazard-free, ready-target instructions bypass the entry combinationally.
module exu_disp
  import exu_disp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [DECINFO_WIDTH-1:0] i_info,
  input  logic [RFIDX_WIDTH-1:0]   i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0]   i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0]   i_rdidx,
  input  logic                     i_rs1en,
  input  logic                     i_rs2en,
  input  logic                     i_rdwen,
  input  logic                     i_illegal,
  input  logic [XLEN-1:0]          i_imm,
  input  logic [PC_SIZE-1:0]       i_pc,
  output logic [3:0]               o_valid,
  input  logic [3:0]               o_ready,
  output logic [DECINFO_WIDTH-1:0] o_info,
  output logic [XLEN-1:0]          o_imm,
  output logic [PC_SIZE-1:0]       o_pc,
  output logic [RFIDX_WIDTH-1:0]   o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]   o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]   o_rdidx,
  output logic                     o_rdwen,
  input  logic                     wb_valid,
  input  logic [RFIDX_WIDTH-1:0]   wb_rdidx,
  input  logic                     flush,
  output logic                     o_excp_valid,
  output logic [PC_SIZE-1:0]       o_excp_pc
);

  disp_state_e state, state_nxt;

  logic [DECINFO_WIDTH-1:0] e_info;
  logic [RFIDX_WIDTH-1:0]   e_rs1idx, e_rs2idx, e_rdidx;
  logic                     e_rs1en, e_rs2en, e_rdwen, e_illegal;
  logic [XLEN-1:0]          e_imm;
  logic [PC_SIZE-1:0]       e_pc;

  logic                     use_in, load, pass, fire, hazard, excp;
  logic [3:0]               sel;
  logic [NUM_REGS-1:0]      pending;

`ifdef EXU_DISP_PASSTHRU_EN
  assign use_in = (state == ST_IDLE);
`else
  assign use_in = 1'b0;
`endif

  // Unit-side payload comes from the entry, or straight from the decoder when bypassing.
  assign o_info   = use_in ? i_info   : e_info;
  assign o_imm    = use_in ? i_imm    : e_imm;
  assign o_pc     = use_in ? i_pc     : e_pc;
  assign o_rs1idx = use_in ? i_rs1idx : e_rs1idx;
  assign o_rs2idx = use_in ? i_rs2idx : e_rs2idx;
  assign o_rdidx  = use_in ? i_rdidx  : e_rdidx;
  assign o_rdwen  = use_in ? i_rdwen  : e_rdwen;

  assign sel  = grp_onehot(decinfo_grp(o_info));
  assign fire = |(o_valid & o_ready);

  exu_disp_sboard u_sboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (fire & sets_pending(o_info) & o_rdwen),
    .set_idx (o_rdidx),
    .clr_en  (wb_valid),
    .clr_idx (wb_rdidx),
    .rs1en   (use_in ? i_rs1en : e_rs1en),
    .rs1idx  (o_rs1idx),
    .rs2en   (use_in ? i_rs2en : e_rs2en),
    .rs2idx  (o_rs2idx),
    .rdwen   (o_rdwen),
    .rdidx   (o_rdidx),
    .hazard  (hazard),
    .pending (pending)
  );

  always_comb begin
    state_nxt = state;
    o_valid   = 4'b0000;
    i_ready   = 1'b0;
    excp      = 1'b0;
    load      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_IDLE: begin
        i_ready = 1'b1;
`ifdef EXU_DISP_PASSTHRU_EN
        if (i_valid && !i_illegal && !hazard && (|(sel & o_ready))) begin
          o_valid = sel;
          pass    = 1'b1;
        end
`endif
        if (i_valid && !pass) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (e_illegal) begin
          excp      = 1'b1;
          i_ready   = 1'b1;
          load      = i_valid;
          state_nxt = ST_TRAP;
        end else begin
          if (!hazard) o_valid = sel;
          if (|(o_valid & o_ready)) begin
            i_ready = 1'b1;
            if (i_valid) load = 1'b1;
            else         state_nxt = ST_IDLE;
          end
        end
      end
      ST_TRAP: ;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      o_valid   = 4'b0000;
      excp      = 1'b0;
      load      = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  assign o_excp_valid = excp;
  assign o_excp_pc    = excp ? e_pc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_info    <= '0;
      e_rs1idx  <= '0;
      e_rs2idx  <= '0;
      e_rdidx   <= '0;
      e_rs1en   <= 1'b0;
      e_rs2en   <= 1'b0;
      e_rdwen   <= 1'b0;
      e_illegal <= 1'b0;
      e_imm     <= '0;
      e_pc      <= '0;
    end else if (load) begin
      e_info    <= i_info;
      e_rs1idx  <= i_rs1idx;
      e_rs2idx  <= i_rs2idx;
      e_rdidx   <= i_rdidx;
      e_rs1en   <= i_rs1en;
      e_rs2en   <= i_rs2en;
      e_rdwen   <= i_rdwen;
      e_illegal <= i_illegal;
      e_imm     <= i_imm;
      e_pc      <= i_pc;
    end
  end

endmodule
